fp_acc_issue_ctrl: RTL

//   Upstream sequencer for the fp_add_sub pipeline. Accepts a packet of IEEE-754 single floats over

---
 rtl/fp_acc_pkg.sv | 30 +++
 rtl/fp_acc_lat_timer.sv | 49 ++++
 rtl/fp_acc_issue_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fp_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_acc_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               fp_acc_issue_ctrl accumulator sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package fp_acc_pkg;

   localparam int              FP_W        = 32;
   localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

   // fp_add_sub opSel encoding
   localparam logic OPSEL_ADD = 1'b1;
   localparam logic OPSEL_SUB = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // True for +0 and -0 (sign bit ignored).
   function automatic logic is_fp_zero(input logic [FP_W-1:0] f);
      return (f[FP_W-2:0] == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_acc_lat_timer.sv
`default_nettype none
// ============================================================================
// Module      : fp_acc_lat_timer
// Description : Loadable down-counter that times out the fp_add_sub pipeline.
//               'load' sets the count to ADDER_LATENCY; while 'dec' is high
//               the count steps down each edge and 'done' is asserted on the
//               cycle the count has reached zero.
// Revision    : 1.0  initial release
// Ports       : clk, areset_n  clock / async active-low reset
//               load           reload the counter with ADDER_LATENCY
//               dec            count down (waiting on the adder)
//               done           dec && count == 0
// ============================================================================
module fp_acc_lat_timer #(
   parameter int ADDER_LATENCY = 5
) (
   input  logic clk,
   input  logic areset_n,
   input  logic load,
   input  logic dec,
   output logic done
);

   localparam int LAT_W = $clog2(ADDER_LATENCY + 1);

   logic [LAT_W-1:0] cnt_q;
   logic [LAT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LAT_W'(ADDER_LATENCY);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - LAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = dec && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/fp_acc_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fp_acc_issue_ctrl
// Description : Upstream sequencer for fp_add_sub. Accepts a packet of
//               single-precision floats, issues one add/sub per element with
//               the running accumulator as operand A, waits out the adder
//               latency, and presents the final sum on a valid/ready output.
// Revision    : 1.0  initial release
// Options     : FP_ACC_ZERO_SKIP_EN - when defined, +0/-0 elements are
//               accepted and counted but not issued to the adder.
// Ports       : clk, areset_n        clock / async active-low reset
//               in_valid/in_ready    element handshake
//               in_data/in_sub/in_last element value, 1=subtract, last flag
//               out_valid/out_ready  sum handshake
//               out_sum/out_count    accumulated sum, elements in packet
//               fp_en/fp_a/fp_b/fp_opSel  operands to fp_add_sub (1=ADD)
//               fp_q                 result from fp_add_sub
// ============================================================================
module fp_acc_issue_ctrl
   import fp_acc_pkg::*;
#(
   parameter int ADDER_LATENCY = 5,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FP_W-1:0]  in_data,
   input  logic             in_sub,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_W-1:0]  out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             fp_en,
   output logic [FP_W-1:0]  fp_a,
   output logic [FP_W-1:0]  fp_b,
   output logic             fp_opSel,
   input  logic [FP_W-1:0]  fp_q
);

   state_t           state_q,     state_d;
   logic [FP_W-1:0]  acc_q,       acc_d;
   logic [FP_W-1:0]  fp_a_q,      fp_a_d;
   logic [FP_W-1:0]  fp_b_q,      fp_b_d;
   logic             fp_opsel_q,  fp_opsel_d;
   logic             fp_en_q,     fp_en_d;
   logic             out_valid_q, out_valid_d;
   logic [FP_W-1:0]  out_sum_q,   out_sum_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             last_q,      last_d;

   logic             lat_load;
   logic             lat_dec;
   logic             lat_done;
   logic             accept;
   logic             skip;

   fp_acc_lat_timer #(
      .ADDER_LATENCY (ADDER_LATENCY)
   ) u_lat_timer (
      .clk      (clk),
      .areset_n (areset_n),
      .load     (lat_load),
      .dec      (lat_dec),
      .done     (lat_done)
   );

   assign in_ready = (state_q == IDLE) || (state_q == RUN);
   assign accept   = in_valid && in_ready;

`ifdef FP_ACC_ZERO_SKIP_EN
   assign skip = is_fp_zero(in_data);
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      fp_a_d      = fp_a_q;
      fp_b_d      = fp_b_q;
      fp_opsel_d  = fp_opsel_q;
      fp_en_d     = 1'b1;          // adder kept enabled once out of reset
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      last_d      = last_q;
      lat_load    = 1'b0;
      lat_dec     = 1'b0;

      case (state_q)
         IDLE, RUN: begin
            if (accept) begin
               last_d = in_last;
               if (state_q == IDLE) begin
                  out_count_d = CNT_W'(1);
               end else if (out_count_q != {CNT_W{1'b1}}) begin
                  out_count_d = out_count_q + CNT_W'(1);
               end

               if (skip) begin
                  // Zero element: operands untouched, accumulator unchanged
                  // (a packet starting with zero starts from +0).
                  if (state_q == IDLE) begin
                     acc_d = FP_POS_ZERO;
                  end
                  if (in_last) begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                     out_sum_d   = (state_q == IDLE) ? FP_POS_ZERO : acc_q;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  fp_a_d     = (state_q == IDLE) ? FP_POS_ZERO : acc_q;
                  fp_b_d     = in_data;
                  fp_opsel_d = in_sub ? OPSEL_SUB : OPSEL_ADD;
                  lat_load   = 1'b1;
                  state_d    = WAIT;
               end
            end
         end

         WAIT: begin
            lat_dec = 1'b1;
            // Result is sampled on the (ADDER_LATENCY+1)-th edge after issue.
            if (lat_done) begin
               acc_d = fp_q;
               if (last_q) begin
                  out_sum_d   = fp_q;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q     <= IDLE;
         acc_q       <= FP_POS_ZERO;
         fp_a_q      <= FP_POS_ZERO;
         fp_b_q      <= FP_POS_ZERO;
         fp_opsel_q  <= OPSEL_ADD;
         fp_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= FP_POS_ZERO;
         out_count_q <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         fp_a_q      <= fp_a_d;
         fp_b_q      <= fp_b_d;
         fp_opsel_q  <= fp_opsel_d;
         fp_en_q     <= fp_en_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         last_q      <= last_d;
      end
   end

   assign fp_en     = fp_en_q;
   assign fp_a      = fp_a_q;
   assign fp_b      = fp_b_q;
   assign fp_opSel  = fp_opsel_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;

endmodule
`default_nettype wire
